// File: rtl/al_pkg.sv
// al_pkg
// Shared types, limits and helpers for the alarm-clock time keeping logic.
// Times are packed BCD HH:MM in 24-hour format.
//   bcd_digit_t  : one BCD digit
//   hhmm_t       : {ms_hour, ls_hour, ms_min, ls_min}
//   hhmm_valid() : 1 when every digit is a legal clock digit for its position
package al_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t ms_hour;
        bcd_digit_t ls_hour;
        bcd_digit_t ms_min;
        bcd_digit_t ls_min;
    } hhmm_t;

    localparam bcd_digit_t MAX_MS_HOUR      = 4'd2;
    localparam bcd_digit_t MAX_LS_HOUR_AT_2 = 4'd3;
    localparam bcd_digit_t MAX_MS_MIN       = 4'd5;
    localparam bcd_digit_t MAX_DIGIT        = 4'd9;

    function automatic logic hhmm_valid(input hhmm_t v);
        logic ok;
        ok = (v.ms_hour <= MAX_MS_HOUR) && (v.ls_hour <= MAX_DIGIT) &&
             (v.ms_min  <= MAX_MS_MIN)  && (v.ls_min  <= MAX_DIGIT);
        // 20..23 are the only legal hours with a leading 2
        if ((v.ms_hour == MAX_MS_HOUR) && (v.ls_hour > MAX_LS_HOUR_AT_2)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_hhmm_inc.sv
// bcd_hhmm_inc
// Combinational one-minute increment of a packed BCD HH:MM value.
//   cur  : current time (assumed valid)
//   nxt  : cur + 1 minute, wrapping 23:59 -> 00:00
//   wrap : 1 when this increment is the 23:59 -> 00:00 wrap
module bcd_hhmm_inc
    import al_pkg::*;
(
    input  hhmm_t cur,
    output hhmm_t nxt,
    output logic  wrap
);

    always_comb begin
        nxt  = cur;
        wrap = 1'b0;
        if (cur.ls_min != MAX_DIGIT) begin
            nxt.ls_min = cur.ls_min + 4'd1;
        end else begin
            nxt.ls_min = 4'd0;
            if (cur.ms_min != MAX_MS_MIN) begin
                nxt.ms_min = cur.ms_min + 4'd1;
            end else begin
                nxt.ms_min = 4'd0;
                if ((cur.ms_hour == MAX_MS_HOUR) && (cur.ls_hour == MAX_LS_HOUR_AT_2)) begin
                    nxt.ms_hour = 4'd0;
                    nxt.ls_hour = 4'd0;
                    wrap        = 1'b1;
                end else if (cur.ls_hour != MAX_DIGIT) begin
                    nxt.ls_hour = cur.ls_hour + 4'd1;
                end else begin
                    nxt.ls_hour = 4'd0;
                    nxt.ms_hour = cur.ms_hour + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/al_time_keeper.sv
// al_time_keeper
// Running time of day plus alarm setting for the alarm clock.
//   clk256, reset         : clock and asynchronous active-high reset
//   one_minute            : advance the time by one minute
//   load_new_time         : load new_value into the time register (wins over one_minute)
//   load_alarm            : load new_value into the alarm register and arm it
//   show_alarm            : 1 = digits show alarm, 0 = digits show time
//   alarm_ack             : silence a sounding alarm
//   new_value             : BCD {ms_hour, ls_hour, ms_min, ls_min}
//   bcd_*                 : display digits (combinational mux of the registers)
//   sound_alarm           : alarm sounding level
//   load_error            : one-cycle pulse after an invalid load
//   rollover              : one-cycle pulse after a 23:59 -> 00:00 tick
module al_time_keeper
    import al_pkg::*;
#(
    parameter int ALARM_MINUTES = 1
) (
    input  logic        clk256,
    input  logic        reset,
    input  logic        one_minute,
    input  logic        load_new_time,
    input  logic        load_alarm,
    input  logic        show_alarm,
    input  logic        alarm_ack,
    input  logic [15:0] new_value,
    output logic [3:0]  bcd_ms_hour,
    output logic [3:0]  bcd_ls_hour,
    output logic [3:0]  bcd_ms_min,
    output logic [3:0]  bcd_ls_min,
    output logic        sound_alarm,
    output logic        load_error,
    output logic        rollover
);

    hhmm_t      time_q, time_d;
    hhmm_t      alarm_q, alarm_d;
    logic       armed_q, armed_d;
    logic       sounding_q, sounding_d;
    logic [3:0] cnt_q, cnt_d;
    logic       load_error_q, load_error_d;
    logic       rollover_q, rollover_d;

    hhmm_t      time_inc;
    hhmm_t      new_hhmm;
    hhmm_t      shown;
    logic       inc_wrap;
    logic       new_valid;

    assign new_hhmm  = hhmm_t'(new_value);
    assign new_valid = hhmm_valid(new_hhmm);

    bcd_hhmm_inc u_inc (
        .cur  (time_q),
        .nxt  (time_inc),
        .wrap (inc_wrap)
    );

    always_comb begin
        time_d       = time_q;
        alarm_d      = alarm_q;
        armed_d      = armed_q;
        sounding_d   = sounding_q;
        cnt_d        = cnt_q;
        load_error_d = 1'b0;
        rollover_d   = 1'b0;

        // A load drops a coincident tick entirely, including its rollover.
        if (load_new_time) begin
            if (new_valid) begin
                time_d = new_hhmm;
            end else begin
                load_error_d = 1'b1;
            end
        end else if (one_minute) begin
            time_d     = time_inc;
            rollover_d = inc_wrap;
        end

        if (load_alarm) begin
            if (new_valid) begin
                alarm_d    = new_hhmm;
                armed_d    = 1'b1;
                sounding_d = 1'b0;
            end else begin
                load_error_d = 1'b1;
            end
        end

        // Minute countdown of an unacknowledged alarm.
        if (one_minute && sounding_q) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_d == 4'd0) begin
                sounding_d = 1'b0;
            end
        end

        // Trigger only on a change of the time register, compared against the
        // alarm state as it will be after this edge.
        if ((time_d != time_q) && armed_d && (time_d == alarm_d)) begin
            sounding_d = 1'b1;
            cnt_d      = 4'(ALARM_MINUTES);
        end

        if (alarm_ack) begin
            sounding_d = 1'b0;
        end
    end

    always_ff @(posedge clk256 or posedge reset) begin
        if (reset) begin
            time_q       <= '0;
            alarm_q      <= '0;
            armed_q      <= 1'b0;
            sounding_q   <= 1'b0;
            cnt_q        <= 4'd0;
            load_error_q <= 1'b0;
            rollover_q   <= 1'b0;
        end else begin
            time_q       <= time_d;
            alarm_q      <= alarm_d;
            armed_q      <= armed_d;
            sounding_q   <= sounding_d;
            cnt_q        <= cnt_d;
            load_error_q <= load_error_d;
            rollover_q   <= rollover_d;
        end
    end

    assign shown       = show_alarm ? alarm_q : time_q;
    assign bcd_ms_hour = shown.ms_hour;
    assign bcd_ls_hour = shown.ls_hour;
    assign bcd_ms_min  = shown.ms_min;
    assign bcd_ls_min  = shown.ls_min;

    assign sound_alarm = sounding_q;
    assign load_error  = load_error_q;
    assign rollover    = rollover_q;

endmodule

// File: tb/tb_al_time_keeper.sv
// tb_al_time_keeper
// Self-checking bench for al_time_keeper: directed vector table, hand-written
// reset / next-day sequences and randomized traffic, all checked against a
// minutes-of-day reference model.
module tb_al_time_keeper;

    localparam int ALARM_MINUTES = 1;

    logic        clk256 = 1'b0;
    logic        reset  = 1'b0;
    logic        one_minute = 1'b0;
    logic        load_new_time = 1'b0;
    logic        load_alarm = 1'b0;
    logic        show_alarm = 1'b0;
    logic        alarm_ack = 1'b0;
    logic [15:0] new_value = 16'h0000;
    logic [3:0]  bcd_ms_hour, bcd_ls_hour, bcd_ms_min, bcd_ls_min;
    logic        sound_alarm, load_error, rollover;

    int n_tests = 0;
    int n_fail  = 0;

    al_time_keeper #(.ALARM_MINUTES(ALARM_MINUTES)) dut (
        .clk256        (clk256),
        .reset         (reset),
        .one_minute    (one_minute),
        .load_new_time (load_new_time),
        .load_alarm    (load_alarm),
        .show_alarm    (show_alarm),
        .alarm_ack     (alarm_ack),
        .new_value     (new_value),
        .bcd_ms_hour   (bcd_ms_hour),
        .bcd_ls_hour   (bcd_ls_hour),
        .bcd_ms_min    (bcd_ms_min),
        .bcd_ls_min    (bcd_ls_min),
        .sound_alarm   (sound_alarm),
        .load_error    (load_error),
        .rollover      (rollover)
    );

    // ---------------- clock ----------------
    always #5 clk256 = ~clk256;

    // ---------------- reference model (minutes of the day) ----------------
    int m_time, m_alarm, m_cnt;
    bit m_armed, m_snd, m_err, m_roll;

    function automatic bit ref_valid(input logic [15:0] v);
        int h;
        if (v[15:12] > 9 || v[11:8] > 9 || v[7:4] > 5 || v[3:0] > 9) return 1'b0;
        h = int'(v[15:12]) * 10 + int'(v[11:8]);
        return h < 24;
    endfunction

    function automatic int bcd_to_min(input logic [15:0] v);
        return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] min_to_bcd(input int m);
        int h, mi;
        h  = m / 60;
        mi = m % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10)};
    endfunction

    task automatic model_reset();
        m_time = 0; m_alarm = 0; m_cnt = 0;
        m_armed = 0; m_snd = 0; m_err = 0; m_roll = 0;
    endtask

    task automatic model_update(input bit lnt, input bit la, input bit om,
                                input bit ack, input logic [15:0] nv);
        int  old_time;
        bit  was_snd;
        old_time = m_time;
        was_snd  = m_snd;
        m_err  = 0;
        m_roll = 0;
        if (lnt) begin
            if (ref_valid(nv)) m_time = bcd_to_min(nv);
            else m_err = 1;
        end else if (om) begin
            m_time = (m_time + 1) % 1440;
            m_roll = (m_time == 0);
        end
        if (la) begin
            if (ref_valid(nv)) begin
                m_alarm = bcd_to_min(nv);
                m_armed = 1;
                m_snd   = 0;
            end else begin
                m_err = 1;
            end
        end
        if (om && was_snd) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_snd = 0;
        end
        if (m_time != old_time && m_armed && m_time == m_alarm) begin
            m_snd = 1;
            m_cnt = ALARM_MINUTES;
        end
        if (ack) m_snd = 0;
    endtask

    // ---------------- checking ----------------
    function automatic logic [18:0] dut_vec();
        return {bcd_ms_hour, bcd_ls_hour, bcd_ms_min, bcd_ls_min, sound_alarm, load_error, rollover};
    endfunction

    task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got digits=%h snd=%b err=%b roll=%b, expected digits=%h snd=%b err=%b roll=%b",
                     name, got[18:3], got[2], got[1], got[0], exp[18:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_model(input string name);
        logic [15:0] d;
        d = show_alarm ? min_to_bcd(m_alarm) : min_to_bcd(m_time);
        check(name, dut_vec(), {d, m_snd, m_err, m_roll});
    endtask

    // ---------------- drivers ----------------
    task automatic step(input bit lnt, input bit la, input bit om, input bit ack,
                        input bit sh, input logic [15:0] nv, input string name);
        load_new_time = lnt;
        load_alarm    = la;
        one_minute    = om;
        alarm_ack     = ack;
        show_alarm    = sh;
        new_value     = nv;
        model_update(lnt, la, om, ack, nv);
        @(posedge clk256);
        #1;
        load_new_time = 1'b0;
        load_alarm    = 1'b0;
        one_minute    = 1'b0;
        alarm_ack     = 1'b0;
        check_model(name);
    endtask

    task automatic do_reset();
        load_new_time = 1'b0; load_alarm = 1'b0; one_minute = 1'b0;
        alarm_ack = 1'b0; show_alarm = 1'b0; new_value = 16'h0000;
        reset = 1'b1;
        @(posedge clk256);
        @(posedge clk256);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          lnt, la, om, ack, sh;
        logic [15:0] nv;
        logic [15:0] e_dig;
        bit          e_snd, e_err, e_roll;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit lnt, input bit la, input bit om, input bit ack,
                                input bit sh, input logic [15:0] nv, input logic [15:0] e_dig,
                                input bit e_snd, input bit e_err, input bit e_roll);
        vec_t v;
        v.lnt = lnt; v.la = la; v.om = om; v.ack = ack; v.sh = sh; v.nv = nv;
        v.e_dig = e_dig; v.e_snd = e_snd; v.e_err = e_err; v.e_roll = e_roll;
        tbl.push_back(v);
    endfunction

    initial begin
        //  lnt la om ack sh  new_value  digits    snd err roll
        add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);  // idle after reset
        add(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);  // arm 00:00, no trigger
        add(1, 0, 0, 0, 0, 16'h2359, 16'h2359, 0, 0, 0);
        add(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 1);  // wrap, alarm at 00:00
        add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);  // rollover one cycle only
        add(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);
        add(1, 0, 0, 0, 0, 16'h0959, 16'h0959, 0, 0, 0);
        add(0, 0, 1, 0, 0, 16'h0000, 16'h1000, 0, 0, 0);
        add(1, 0, 0, 0, 0, 16'h1959, 16'h1959, 0, 0, 0);
        add(0, 0, 1, 0, 0, 16'h0000, 16'h2000, 0, 0, 0);
        add(1, 0, 0, 0, 0, 16'h1209, 16'h1209, 0, 0, 0);
        add(0, 0, 1, 0, 0, 16'h0000, 16'h1210, 0, 0, 0);
        add(1, 0, 0, 0, 0, 16'h0815, 16'h0815, 0, 0, 0);
        add(1, 0, 0, 0, 0, 16'h2400, 16'h0815, 0, 1, 0);
        add(1, 0, 0, 0, 0, 16'h1260, 16'h0815, 0, 1, 0);
        add(1, 0, 0, 0, 0, 16'h0A15, 16'h0815, 0, 1, 0);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h0815, 0, 0, 0);  // error pulse one cycle
        add(0, 1, 0, 0, 1, 16'h0730, 16'h0730, 0, 0, 0);  // shows alarm
        add(1, 0, 0, 0, 0, 16'h0729, 16'h0729, 0, 0, 0);
        add(0, 0, 1, 0, 0, 16'h0000, 16'h0730, 1, 0, 0);  // trigger
        add(0, 0, 0, 0, 1, 16'h0000, 16'h0730, 1, 0, 0);
        add(0, 0, 1, 0, 0, 16'h0000, 16'h0731, 0, 0, 0);  // one minute elapsed
        add(1, 0, 0, 0, 0, 16'h0729, 16'h0729, 0, 0, 0);
        add(0, 0, 1, 0, 0, 16'h0000, 16'h0730, 1, 0, 0);
        add(0, 0, 0, 1, 0, 16'h0000, 16'h0730, 0, 0, 0);  // ack
        add(1, 0, 1, 0, 0, 16'h0500, 16'h0500, 0, 0, 0);  // tick dropped
        add(1, 0, 0, 0, 0, 16'h0400, 16'h0400, 0, 0, 0);
        add(1, 1, 1, 0, 0, 16'h0500, 16'h0500, 1, 0, 0);  // load both + trigger
        add(0, 0, 0, 1, 0, 16'h0000, 16'h0500, 0, 0, 0);
        add(1, 0, 0, 0, 0, 16'h0459, 16'h0459, 0, 0, 0);
        add(0, 0, 1, 1, 0, 16'h0000, 16'h0500, 0, 0, 0);  // ack beats trigger
    end

    // ---------------- test sequence ----------------
    initial begin
        int r;
        bit lnt, la, om, ack, sh;
        logic [15:0] nv;

        #2;
        do_reset();
        check("reset_state", dut_vec(), 19'h0);

        // Reset while sounding at 12:34.
        step(0, 1, 0, 0, 0, 16'h1234, "arm_1234");
        step(1, 0, 0, 0, 0, 16'h1233, "load_1233");
        step(0, 0, 1, 0, 0, 16'h0000, "trigger_1234");
        check("sounding_1234", dut_vec(), {16'h1234, 1'b1, 1'b0, 1'b0});
        #2;
        reset = 1'b1;
        #1;
        check("reset_async", dut_vec(), 19'h0);
        model_reset();
        @(posedge clk256);
        #1;
        reset = 1'b0;
        step(0, 0, 1, 0, 0, 16'h0000, "first_tick_model");
        check("first_tick_after_reset", dut_vec(), {16'h0001, 1'b0, 1'b0, 1'b0});
        step(0, 1, 0, 0, 0, 16'h0000, "arm_0000_model");
        step(0, 0, 0, 0, 0, 16'h0000, "idle_model");
        check("load_alarm_no_trigger", dut_vec(), {16'h0001, 1'b0, 1'b0, 1'b0});

        // Directed table.
        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].lnt, tbl[i].la, tbl[i].om, tbl[i].ack, tbl[i].sh, tbl[i].nv,
                 $sformatf("tbl_model_%0d", i));
            check($sformatf("tbl_%0d", i), dut_vec(),
                  {tbl[i].e_dig, tbl[i].e_snd, tbl[i].e_err, tbl[i].e_roll});
        end

        // Alarm stays armed: 24 h of ticks later it fires again.
        for (int i = 0; i < 1440; i++) begin
            step(0, 0, 1, 0, 0, 16'h0000, "day_ticks");
        end
        check("fires_next_day", dut_vec(), {16'h0500, 1'b1, 1'b0, 1'b0});

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            r   = $urandom_range(0, 99);
            om  = (r < 45);
            lnt = ($urandom_range(0, 9) == 0);
            la  = ($urandom_range(0, 11) == 0);
            ack = ($urandom_range(0, 19) == 0);
            sh  = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       nv = 16'($urandom);
                1:       nv = min_to_bcd($urandom_range(0, 1439));
                default: nv = min_to_bcd((m_time + $urandom_range(1, 3)) % 1440);
            endcase
            step(lnt, la, om, ack, sh, nv, "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/al_time_keeper.md
# al_time_keeper

Holds the running time of day and the alarm setting for the alarm clock, both as packed BCD HH:MM in 24-hour format. It advances time on the `one_minute` pulse from the time generator. It accepts load strobes from the alarm controller, with new values taken from the keyboard key buffer, and drives the four BCD digits consumed by the seven-segment display driver. It also raises `sound_alarm` when the running time reaches the armed alarm time.

## Interface
Parameters:
- `ALARM_MINUTES`, 1: number of `one_minute` ticks `sound_alarm` stays high if not acknowledged; legal range 1–15.

Ports:
- `clk256`  in  1  block clock, 256 Hz tick domain
- `reset`  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- `one_minute`  in  1  single-cycle advance strobe
- `load_new_time`  in  1  single-cycle strobe: load `new_value` into time register
- `load_alarm`  in  1  single-cycle strobe: load `new_value` into alarm register, arm alarm
- `show_alarm`  in  1  level: 1 = digits show alarm register, 0 = time register
- `alarm_ack`  in  1  single-cycle strobe: silence alarm
- `new_value`  in  16  BCD `{ms_hour, ls_hour, ms_min, ls_min}`
- `bcd_ms_hour`, `bcd_ls_hour`, `bcd_ms_min`, `bcd_ls_min`  out  4 each  display digits
- `sound_alarm`  out  1  level, registered
- `load_error`  out  1  single-cycle pulse, registered
- `rollover`  out  1  single-cycle pulse at 23:59→00:00, registered

## Operation
- Registers:
  - time register (16 b)
  - alarm register (16 b)
  - `armed` flag
  - `sounding` flag
  - minute-down counter (4 b)
- Reset values:
  - time = 00:00, alarm = 00:00, `armed` = 0
  - all outputs 0; digits 0x0
- Validity: a `new_value` is valid iff every digit ≤ 9, `ms_min` ≤ 5, and hours ≤ 23 (`ms_hour` ≤ 2; `ls_hour` ≤ 3 when `ms_hour` = 2).
- Invalid load:
  - the target register is unchanged
  - `load_error` pulses
  - `armed` is unchanged on an invalid `load_alarm`
- Increment on `one_minute`:
  - `ls_min` 9→0 carries into `ms_min`
  - `ms_min` 5→0 carries into hours
  - `ls_hour` 9→0 carries into `ms_hour`
  - 23:59→00:00 and pulses `rollover`
- Priority, time register: `load_new_time` > `one_minute`. On a same-cycle collision the tick is dropped, with no increment and no `rollover`.
- `load_new_time` and `load_alarm` in the same cycle: both registers load independently. `load_error` pulses once if either value is invalid.
- Alarm trigger:
  - evaluated only when the time register changes value (tick or valid load), using the new value
  - if `armed` and new time == alarm, set `sounding` and load the down-counter with `ALARM_MINUTES`
  - reset and `load_alarm` never trigger on their own
- Sounding:
  - each `one_minute` tick decrements the counter; `sounding` clears when the counter reaches 0
  - `alarm_ack` clears `sounding` immediately
  - a valid `load_alarm` clears `sounding`
  - `armed` stays 1, so the alarm fires again the next day
- Trigger and `alarm_ack` in the same cycle: `alarm_ack` wins, `sounding` stays 0.
- Digits are a combinational mux of the alarm register (`show_alarm` = 1) or the time register (`show_alarm` = 0).

## Timing
- Register updates occur on the `clk256` edge sampling the strobe.
- Digits reflect the new value immediately after that edge (0-cycle latency beyond the register).
- `show_alarm` toggle: digits change combinationally, same cycle.
- `sound_alarm`, `load_error`, `rollover`: high for the cycle following the causing edge.
  - `sound_alarm` is a level.
  - `load_error` and `rollover` are exactly one cycle wide.
- Reset mid-operation: all state clears asynchronously, including a sounding alarm and `armed`. The first tick after release advances 00:00→00:01.
- Strobes are assumed single-cycle. A held strobe acts once per cycle; no edge detection is performed.

## Structure
- Shared package `al_pkg`:
  - `bcd_digit_t` (4 b)
  - `hhmm_t` packed struct `{ms_hour, ls_hour, ms_min, ls_min}`
  - constants `MAX_MS_HOUR` = 2, `MAX_LS_HOUR_AT_2` = 3, `MAX_MS_MIN` = 5
  - function `hhmm_valid()`
- Sub-module `bcd_hhmm_inc`: combinational HH:MM increment, outputs next value and wrap flag. It is reused by the alarm snooze logic later.
- Top contains the registers, priority logic, alarm flags and display mux.

## Test plan
- Reset while sounding at 12:34 → all digits 0, `sound_alarm`/`load_error`/`rollover` 0; `load_alarm` 00:00 with no tick → `sound_alarm` stays 0.
- Load 23:59, one tick → 00:00, `rollover` = 1 for one cycle; load 09:59 → tick → 10:00; 19:59 → 20:00; 12:09 → 12:10.
- Load 0x2400, 0x1260, 0x0A15 → `load_error` pulse each; time unchanged at previous valid 08:15.
- Alarm 07:30, time 07:29, tick → `sound_alarm` = 1 next cycle. With `show_alarm` = 1, digits read 0,7,3,0. With `ALARM_MINUTES` = 1, the next tick clears it. Repeat with `alarm_ack` → clears immediately.
- `load_new_time` 05:00 and `one_minute` in the same cycle → time 05:00, no increment; `load_alarm` 05:00 same cycle → registers match but a trigger occurs only because the time changed (`sound_alarm` = 1).
- Trigger cycle coincident with `alarm_ack` → `sound_alarm` remains 0; 24 h of ticks later → fires again.
